// File: rtl/seq_mult_pl.sv
// Sequential shift-and-add unsigned multiplier. The multiply takes n CALC cycles.
// The 2n-bit product is registered, and a one-cycle pl strobe loads it into a downstream register.
module seq_mult_pl #(
   parameter int n = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   output logic           busy,
   output logic           pl,
   output logic [2*n-1:0] prod
);

   localparam int CW = $clog2(n);
   localparam logic [CW-1:0] CNT_LOAD = CW'(n - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [n-1:0]     mcand_q, mcand_d;
   logic [n-1:0]     mplier_q, mplier_d;
   logic [n-1:0]     acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*n-1:0]   prod_q, prod_d;
   logic             busy_q, busy_d;
   logic             pl_q, pl_d;
   logic [n:0]       addend_s;
   logic [n:0]       sum_s;

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mcand_q  <= {n{1'b0}};
         mplier_q <= {n{1'b0}};
         acc_q    <= {n{1'b0}};
         cnt_q    <= {CW{1'b0}};
         prod_q   <= {(2*n){1'b0}};
         busy_q   <= 1'b0;
         pl_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         busy_q   <= busy_d;
         pl_q     <= pl_d;
      end
   end

   // Next-state logic and one shift-and-add iteration per CALC cycle
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;

      if (mplier_q[0]) begin
         addend_s = {1'b0, mcand_q};
      end else begin
         addend_s = {(n+1){1'b0}};
      end
      sum_s = {1'b0, acc_q} + addend_s;

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = a;
               mplier_d = b;
               acc_d    = {n{1'b0}};
               cnt_d    = CNT_LOAD;
               state_d  = CALC;
            end else begin
               state_d  = IDLE;
            end
         end
         CALC: begin
            // Shift {carry, acc, multiplier} right by one; the low product bits collect in the multiplier
            acc_d    = sum_s[n:1];
            mplier_d = {sum_s[0], mplier_q[n-1:1]};
            if (cnt_q == {CW{1'b0}}) begin
               prod_d  = {sum_s[n:1], sum_s[0], mplier_q[n-1:1]};
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q - CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      pl_d   = (state_d == DONE);
   end

   assign busy = busy_q;
   assign pl   = pl_q;
   assign prod = prod_q;

endmodule

// File: tb/tb_seq_mult_pl.sv
// Directed self-checking bench for seq_mult_pl (n=32): latency, products, back-to-back,
// operand/start isolation during CALC, and mid-operation reset.
module tb_seq_mult_pl;

   localparam int N = 32;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [N-1:0]    a;
   logic [N-1:0]    b;
   logic            busy;
   logic            pl;
   logic [2*N-1:0]  prod;

   int total = 0;
   int bad   = 0;

   seq_mult_pl #(.n(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .pl    (pl),
      .prod  (prod)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: pulses start for one cycle and watches 40 cycles after the capture edge.
   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [63:0] exp, input bit disturb);
      int            busy_cnt = 0;
      int            pl_cnt   = 0;
      int            pl_cyc   = 0;
      bit            changed  = 1'b0;
      logic [63:0]   prod0;
      logic [63:0]   prod_at_pl = 64'd0;
      prod0 = prod;
      a = ta;
      b = tb_v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge clk);
         if (busy) busy_cnt++;
         if (pl) begin
            pl_cnt++;
            pl_cyc = c;
            prod_at_pl = prod;
         end else if (pl_cnt == 0 && prod !== prod0) begin
            changed = 1'b1;
         end
         if (disturb && c == 5) begin
            a = 32'hCAFE_0001;
            b = 32'h1234_5677;
            start = 1'b1;
         end
         if (disturb && c == 6) start = 1'b0;
      end
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
      chk({tag, "_pl_count"},    64'(pl_cnt),   64'd1);
      chk({tag, "_pl_cycle"},    64'(pl_cyc),   64'd33);
      chk({tag, "_prod"},        prod_at_pl,    exp);
      chk({tag, "_prod_stable"}, 64'(changed),  64'd0);
   endtask

   initial begin : stim
      int pl_seen;
      int cyc1;
      int cyc2;
      int busy_after;
      logic [63:0] p1;
      logic [63:0] p2;

      rst_n = 1'b0;
      start = 1'b0;
      a = 32'd0;
      b = 32'd0;
      #3;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_pl",   64'(pl),   64'd0);
      chk("reset_prod", prod,      64'd0);

      @(negedge clk);
      rst_n = 1'b1;
      run_op("op_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
      run_op("op_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
      run_op("op_zero", 32'd0, 32'hDEAD_BEEF, 64'd0, 1'b0);
      run_op("op_mix", 32'h1234_5678, 32'd9, 64'h0000_0000_A3D7_0A38, 1'b0);
      run_op("op_disturb", 32'd100, 32'd200, 64'd20000, 1'b1);

      // Back-to-back with start held high
      pl_seen = 0;
      cyc1 = 0;
      cyc2 = 0;
      p1 = 64'd0;
      p2 = 64'd0;
      a = 32'd7;
      b = 32'd6;
      start = 1'b1;
      @(negedge clk);
      a = 32'h0001_0000;
      b = 32'h0001_0000;
      for (int c = 1; c <= 80; c++) begin
         if (c > 1) @(negedge clk);
         if (pl) begin
            pl_seen++;
            if (pl_seen == 1) begin
               cyc1 = c;
               p1 = prod;
            end else if (pl_seen == 2) begin
               cyc2 = c;
               p2 = prod;
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      chk("b2b_pl_count",  64'(pl_seen),     64'd2);
      chk("b2b_first_cyc", 64'(cyc1),        64'd33);
      chk("b2b_period",    64'(cyc2 - cyc1), 64'd34);
      chk("b2b_prod1",     p1,               64'd42);
      chk("b2b_prod2",     p2,               64'h0000_0001_0000_0000);

      // Reset asserted in CALC cycle 10
      a = 32'd3;
      b = 32'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_reset_busy", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_reset_busy", 64'(busy), 64'd0);
      chk("mid_reset_pl",   64'(pl),   64'd0);
      chk("mid_reset_prod", prod,      64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pl_seen = 0;
      busy_after = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (pl) pl_seen++;
         if (busy) busy_after++;
      end
      chk("abort_no_pl",   64'(pl_seen),    64'd0);
      chk("abort_no_busy", 64'(busy_after), 64'd0);
      run_op("op_after_reset", 32'd12345, 32'd6789, 64'd83810205, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_mult_pl.md
SEQ_MULT_PL -- requirements
Module: seq_mult_pl

Interface
REQ-001 The block SHALL expose parameter n, default 32, giving the operand width in bits (n >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit; the single clock, rising edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit; request to begin a multiply, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, n bits; multiplicand, unsigned.
REQ-006 The block SHALL have port b, input, n bits; multiplier, unsigned.
REQ-007 The block SHALL have port busy, output, 1 bit; high while an operation is in progress.
REQ-008 The block SHALL have port pl, output, 1 bit; one-cycle load strobe for the downstream parallel-load register.
REQ-009 The block SHALL have port prod, output, 2n bits; registered product, the data feeding the downstream register.

Function
REQ-010 The block SHALL implement three states: IDLE, CALC and DONE.
REQ-011 IDLE, start=1 at a rising edge: capture a into the multiplicand register and b into the multiplier shift register, clear the accumulator, load the iteration counter with n-1, and go to CALC.
REQ-012 IDLE, start=0: remain in IDLE with no register change.
REQ-013 CALC, each edge: if multiplier LSB=1, add the multiplicand to the accumulator upper n bits with carry out kept (n+1-bit sum); then shift {carry, accumulator, multiplier} right by one.
REQ-014 CALC: decrement the counter each edge; on the edge where the counter is 0, perform the final iteration, write the full 2n-bit result into prod, and go to DONE.
REQ-015 CALC SHALL therefore last exactly n cycles.
REQ-016 DONE: pl=1 for exactly that one cycle; the next edge returns the block to IDLE unconditionally.
REQ-017 Latency: pl SHALL be high in the cycle following edge E0+n, where E0 is the edge that sampled start.
REQ-018 prod SHALL be valid and stable whenever pl=1.
REQ-019 prod SHALL hold its value from DONE until the next DONE; prod SHALL NOT change during IDLE or CALC.
REQ-020 busy SHALL be high in CALC and DONE and low in IDLE; busy is registered.
REQ-021 pl SHALL be a registered output, high only in DONE.
REQ-022 start in CALC or DONE SHALL be ignored; it is not queued.
REQ-023 Changes on a and b after E0 SHALL NOT affect the result.
REQ-024 start held high continuously SHALL produce back-to-back operations: a new capture at the first IDLE edge after DONE, giving a period of n+2 cycles.
REQ-025 Arithmetic SHALL be exact modulo 2^(2n); no overflow is possible (max (2^n-1)^2 < 2^(2n)).
REQ-026 An operand of 0 SHALL still take the full n CALC cycles and yield prod=0.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE, busy=0, pl=0, prod=0, counter=0, accumulator=0, multiplicand=0, multiplier=0.
REQ-028 Assertion of rst_n during CALC or DONE SHALL abort the operation; no pl pulse is produced for it.
REQ-029 The first start is accepted at the first rising edge after rst_n deasserts.

Verification
REQ-030 n=32, a=3, b=5, start pulsed 1 cycle -> busy high for 33 cycles; pl high in the 33rd of those cycles (DONE); prod=0x000000000000000F.
REQ-031 n=32, a=b=0xFFFFFFFF -> prod=0xFFFFFFFE00000001 when pl=1.
REQ-032 n=32, a=0, b=0xDEADBEEF -> pl high after the same latency as REQ-030; prod=0.
REQ-033 start held high, operand pairs (7,6) then (0x10000,0x10000) presented in time for each capture -> pl pulses 34 cycles apart; prod=42, then 0x0000000100000000.
REQ-034 Operation in CALC, a/b changed and start pulsed mid-operation -> result reflects the original operands; no second operation starts.
REQ-035 rst_n pulled low in CALC cycle 10 -> busy, pl and prod go to 0 immediately; no pl pulse follows; a new start after release gives the correct product.
